// File: rtl/frame_pkg.sv
// frame_pkg: framebuffer geometry, colour width and the sprite draw-state
// encoding shared by every write source of the frame manager.
package frame_pkg;
   localparam int COLOR_DEPTH      = 9;
   localparam int FB_W             = 160;
   localparam int FB_H             = 120;
   localparam int SOURCE_SEL_ADDRW = 3;
   typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} draw_state_e;
endpackage

// File: rtl/sprite_rom.sv
// sprite_rom: synchronous sprite bitmap, one {transparent, colour} word per pixel,
// read in raster order with one cycle of latency.
module sprite_rom #(
   parameter int    SPRITE_W    = 16,
   parameter int    SPRITE_H    = 16,
   parameter int    COLOR_DEPTH = 9,
   parameter string INIT_FILE   = "checker"
) (
   input  logic                                  clk,
   input  logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  addr_i,
   output logic [COLOR_DEPTH:0]                  data_o
);
   int                   col;
   logic [COLOR_DEPTH:0] data_d;
   // "solid" is a fully opaque white block; any other image name yields a
   // raster-index colour ramp with every fourth column see-through.
   always_comb begin
      col    = int'(addr_i) % SPRITE_W;
      data_d = (INIT_FILE == "solid") ? {1'b0, {COLOR_DEPTH{1'b1}}}
                                      : {col % 4 == 3, COLOR_DEPTH'(addr_i)};
   end
   always_ff @(posedge clk)
      data_o <= data_d;
endmodule

// File: rtl/sprite_draw.sv
// sprite_draw: on request from the frame manager, streams one sprite pass onto
// the shared write bus, clipping off-screen pixels to transparent.
module sprite_draw import frame_pkg::*; #(
   parameter int SOURCE_ID   = 3,
   parameter int SPRITE_W    = 16,
   parameter int SPRITE_H    = 16,
   parameter int COLOR_DEPTH = frame_pkg::COLOR_DEPTH
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic [31:0]                 topLeft_x,
   input  logic [31:0]                 topLeft_y,
   input  logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
   input  logic                        write_awaited,
   output logic                        write_active,
   output logic [31:0]                 write_x_addr,
   output logic [31:0]                 write_y_addr,
   output logic [COLOR_DEPTH-1:0]      write_color_data,
   output logic                        write_transparent
);
   localparam int AW = $clog2(SPRITE_W*SPRITE_H);
   localparam int CW = $clog2(SPRITE_W);
   localparam int RW = $clog2(SPRITE_H);
   draw_state_e          state_q, state_d;
   logic                 sel, wrap, last, start, abort;
   logic                 arm_q, arm_d, act_q, act_d, clip_q, clip_d;
   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic signed [31:0]   lx_q, lx_d, ly_q, ly_d, px, py;
   logic [31:0]          x_q, x_d, y_q, y_d;
   logic [AW-1:0]        addr;
   logic [COLOR_DEPTH:0] rom_data;

   assign sel  = write_source_sel == SOURCE_SEL_ADDRW'(SOURCE_ID);
   assign wrap = col_q == CW'(SPRITE_W - 1);
   assign last = wrap && row_q == RW'(SPRITE_H - 1);
   assign addr = AW'(int'(row_q) * SPRITE_W + int'(col_q));

   always_ff @(posedge clk)
      state_q <= !resetN ? IDLE : state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sel && write_awaited && arm_q) state_d = LATCH;
         LATCH:   state_d = sel ? DRAW : IDLE;
         DRAW:    state_d = !sel ? IDLE : last ? DONE : DRAW;
         DONE:    if (!sel || !write_awaited) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // arm_q blocks a new pass until the request has been seen low, except after
   // an abort by deselection, which leaves the pending request to be served.
   always_comb begin
      start  = state_q == IDLE && state_d == LATCH;
      abort  = (state_q == LATCH || state_q == DRAW) && !sel;
      arm_d  = !write_awaited || abort || (arm_q && !start);
      act_d  = state_q == DRAW && sel;
      col_d  = act_d && !wrap ? col_q + 1'b1 : '0;
      row_d  = act_d ? row_q + RW'(wrap) : '0;
      lx_d   = state_q == LATCH ? topLeft_x : lx_q;
      ly_d   = state_q == LATCH ? topLeft_y : ly_q;
      px     = lx_q + 32'(col_q);
      py     = ly_q + 32'(row_q);
      clip_d = act_d && (px < 0 || px >= FB_W || py < 0 || py >= FB_H);
      x_d    = act_d ? px : '0;
      y_d    = act_d ? py : '0;
   end

   always_ff @(posedge clk)
      if (!resetN) begin
         arm_q  <= 1'b0;
         act_q  <= 1'b0;
         clip_q <= 1'b0;
         col_q  <= '0;
         row_q  <= '0;
         lx_q   <= '0;
         ly_q   <= '0;
         x_q    <= '0;
         y_q    <= '0;
      end else begin
         arm_q  <= arm_d;
         act_q  <= act_d;
         clip_q <= clip_d;
         col_q  <= col_d;
         row_q  <= row_d;
         lx_q   <= lx_d;
         ly_q   <= ly_d;
         x_q    <= x_d;
         y_q    <= y_d;
      end

   sprite_rom #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .COLOR_DEPTH(COLOR_DEPTH)) u_rom (
      .clk    (clk),
      .addr_i (addr),
      .data_o (rom_data)
   );

   assign write_active      = sel ? act_q : 1'bz;
   assign write_x_addr      = sel ? x_q : 'z;
   assign write_y_addr      = sel ? y_q : 'z;
   assign write_color_data  = sel ? (act_q ? rom_data[COLOR_DEPTH-1:0] : '0) : 'z;
   assign write_transparent = sel ? act_q & (rom_data[COLOR_DEPTH] | clip_q) : 1'bz;
endmodule

// File: tb/tb_sprite_draw.sv
// tb_sprite_draw: directed passes of a 16x16 sprite checking every pixel against
// the built-in bitmap, clipping, abort, hold-request and reset behaviour.
module tb_sprite_draw;
   import frame_pkg::*;
   logic                        clk = 0, resetN = 0, awaited = 0;
   logic [31:0]                 tlx = 0, tly = 0;
   logic [SOURCE_SEL_ADDRW-1:0] sel = 3;
   wire                         wa, wt;
   wire [31:0]                  wx, wy;
   wire [8:0]                   wc;
   int                          total = 0, bad = 0;

   pulldown (wa);
   always #20 clk = ~clk;

   sprite_draw dut (
      .clk               (clk),
      .resetN            (resetN),
      .topLeft_x         (tlx),
      .topLeft_y         (tly),
      .write_source_sel  (sel),
      .write_awaited     (awaited),
      .write_active      (wa),
      .write_x_addr      (wx),
      .write_y_addr      (wy),
      .write_color_data  (wc),
      .write_transparent (wt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_active"}, 32'(wa), 0);
      chk({tag, "_x"}, wx, 0);
      chk({tag, "_y"}, wy, 0);
      chk({tag, "_color"}, 32'(wc), 0);
      chk({tag, "_transp"}, 32'(wt), 0);
   endtask

   // Trigger already applied; the first pixel must appear 3 sampled edges later.
   task automatic expect_pass(input int lx, input int ly, input bit pulse,
                              input int abort_at, input bit by_reset, input bit chg);
      int n = 0;
      while (n < 8 && wa !== 1'b1) begin
         tick();
         n++;
         if (n == 1 && pulse) awaited = 0;
      end
      chk("first_latency", n, 3);
      if (wa !== 1'b1) return;
      for (int k = 0; k < 256; k++) begin
         int col = k % 16, row = k / 16, x = lx + col, y = ly + row;
         bit t = (col % 4 == 3) || x < 0 || x >= 160 || y < 0 || y >= 120;
         chk("pix_active", 32'(wa), 1);
         chk("pix_x", wx, 32'(x));
         chk("pix_y", wy, 32'(y));
         chk("pix_color", 32'(wc), 32'(k));
         chk("pix_transp", 32'(wt), 32'(t));
         if (chg && k == 100) begin
            tlx = 77;
            tly = 5;
         end
         if (k == abort_at) begin
            if (by_reset) begin
               resetN = 0;
               tick();
               check_zero("rst_mid");
            end else begin
               sel = 0;
               #1;
               chk("desel_released", 32'(wa), 0);
               tick();
               chk("desel_state", 32'(dut.state_q), 32'(IDLE));
            end
            return;
         end
         tick();
      end
      chk("post_active", 32'(wa), 0);
   endtask

   initial begin
      tick();
      tick();
      check_zero("reset");
      resetN = 1;
      tick();
      check_zero("idle");
      // basic pass with a one-cycle request pulse
      tlx = 10; tly = 20; awaited = 1;
      expect_pass(10, 20, 1, -1, 0, 0);
      tick();
      // clipped pass; position moves mid-pass but the latched one must hold
      tlx = -4; tly = 112; awaited = 1;
      expect_pass(-4, 112, 1, -1, 0, 1);
      tick();
      // request held through the end: one pass only, then re-request
      tlx = 30; tly = 40; awaited = 1;
      expect_pass(30, 40, 0, -1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_no_restart", 32'(wa), 0);
      end
      awaited = 0;
      tick();
      awaited = 1;
      expect_pass(30, 40, 1, -1, 0, 0);
      tick();
      // deselect at pixel 100, then reselect with the request still pending
      tlx = 5; tly = 5; awaited = 1;
      expect_pass(5, 5, 0, 100, 0, 0);
      tick();
      chk("desel_idle_released", 32'(wa), 0);
      tlx = 0; tly = 0; sel = 3;
      expect_pass(0, 0, 1, -1, 0, 0);
      tick();
      // reset at pixel 50, release with the request high
      tlx = 1; tly = 2; awaited = 1;
      expect_pass(1, 2, 0, 50, 1, 0);
      resetN = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rst_no_restart", 32'(wa), 0);
      end
      awaited = 0;
      tick();
      awaited = 1;
      expect_pass(1, 2, 1, -1, 0, 0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sprite_draw.md
SPRITE_DRAW -- requirements
Module: sprite_draw

Interface
REQ-001 SHALL have parameter SOURCE_ID, default 3; frame-manager write-source index served by this block.
REQ-002 SHALL have parameter SPRITE_W, default 16; sprite width in pixels.
REQ-003 SHALL have parameter SPRITE_H, default 16; sprite height in pixels.
REQ-004 SHALL have parameter COLOR_DEPTH, default 9; packed RGB width, 3 bits per channel.
REQ-005 SHALL have port clk, input, 1; single clock, the 25 MHz write clock; all logic on its rising edge.
REQ-006 SHALL have port resetN, input, 1; synchronous, active-low reset.
REQ-007 SHALL have port topLeft_x, input, 32; signed sprite x position.
REQ-008 SHALL have port topLeft_y, input, 32; signed sprite y position.
REQ-009 SHALL have port write_source_sel, input, SOURCE_SEL_ADDRW; source currently granted by the frame manager.
REQ-010 SHALL have port write_awaited, input, 1; manager requests a full pass from the selected source.
REQ-011 SHALL have port write_active, output, 1; a valid pixel is presented this cycle.
REQ-012 SHALL have port write_x_addr, output, 32; pixel x.
REQ-013 SHALL have port write_y_addr, output, 32; pixel y.
REQ-014 SHALL have port write_color_data, output, COLOR_DEPTH; pixel colour.
REQ-015 SHALL have port write_transparent, output, 1; the manager skips this pixel.

Function
REQ-016 Selection: all five write_* outputs SHALL be high-impedance whenever write_source_sel != SOURCE_ID, because the bus is shared by all sources.
REQ-017 SHALL implement the state machine IDLE -> LATCH -> DRAW -> DONE -> IDLE.
REQ-018 IDLE->LATCH: when selected and write_awaited=1.
REQ-019 LATCH: SHALL capture topLeft_x and topLeft_y, then go to DRAW; the position is frozen for the whole pass.
REQ-020 DRAW: SHALL step a column/row counter raster-order (col fastest), from (0,0) to (SPRITE_W-1, SPRITE_H-1), one pixel per cycle, no stalls.
REQ-021 Bitmap: SHALL be a synchronous ROM of SPRITE_W*SPRITE_H entries, each COLOR_DEPTH+1 bits (colour plus transparent flag), with 1-cycle read latency; outputs are registered to align with the ROM data.
REQ-022 Throughput: write_active SHALL be high for exactly SPRITE_W*SPRITE_H consecutive cycles per pass; the first pixel appears 2 cycles after leaving IDLE.
REQ-023 Addressing: write_x_addr SHALL equal latched_x+col and write_y_addr SHALL equal latched_y+row, using 32-bit signed arithmetic.
REQ-024 Clipping: a pixel with x<0, x>=FB_W, y<0 or y>=FB_H SHALL be emitted with write_transparent=1; pixel count and timing are unchanged.
REQ-025 The ROM transparent flag SHALL be ORed into write_transparent.
REQ-026 DRAW->DONE: after the last pixel; write_active SHALL drop the cycle after the last pixel.
REQ-027 DONE->IDLE: only once write_awaited=0 or the source is deselected; this guarantees exactly one pass per request.
REQ-028 Deselection: if write_source_sel changes during LATCH or DRAW, the block SHALL abort to IDLE and clear write_active on the next cycle; no partial resume.
REQ-029 Re-request: if write_awaited is still high on the DONE->IDLE exit, it SHALL NOT start a new pass until write_awaited has been low for at least 1 cycle.
REQ-030 Idle outputs: when selected but not drawing, write_active=0, and x, y, colour and write_transparent are 0.

Reset
REQ-031 resetN=0 on a clock edge SHALL force IDLE, zero the counters and latched position, and set write_active=0, x=0, y=0, colour=0, write_transparent=0.
REQ-032 Reset asserted mid-DRAW SHALL abort the pass the same edge; after release, no pass starts until a fresh write_awaited rising edge.

Structure
REQ-033 The shared package frame_pkg SHALL hold COLOR_DEPTH, FB_W=160, FB_H=120, SOURCE_SEL_ADDRW and the draw-state enum typedef.
REQ-034 The ROM SHALL be one sub-module, sprite_rom (parameters SPRITE_W, SPRITE_H, init file), instantiated once.

Verification
REQ-035 Basic pass: pos (10,20), selected, awaited pulse -> 256 active cycles; first pixel (10,20), last pixel (25,35); write_active low after.
REQ-036 Clipping: pos (-4,112) -> still 256 cycles; pixels with x<0 or y>=120 have transparent=1; pixel (0,112) is opaque if the ROM marks it opaque.
REQ-037 Deselect: switch write_source_sel away at pixel 100 -> outputs go Z, next cycle state=IDLE; reselect with awaited -> a full 256-pixel pass from (0,0).
REQ-038 Hold request: write_awaited held high through the end of the pass -> exactly one pass, no restart; drop awaited, then raise it -> a second pass starts.
REQ-039 Reset: resetN=0 at pixel 50 -> next edge all outputs 0 and write_active=0; release with awaited already high -> no pass until awaited toggles.
REQ-040 Position change: topLeft_x changes mid-pass -> addresses follow the latched value for the entire pass.
